// File: rtl/logic_gate_pkg.sv
// Shared constants for the registered bitwise logic unit.
package logic_gate_pkg;

  // Operation select codes
  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_PASS_A = 3'd6;
  localparam logic [2:0] OP_ZERO   = 3'd7;

  // Operating modes
  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Controller states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit bitwise operator: y = f(a, b, op).
module logic_op_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; PASS_A forwards operand a
  always_comb begin
    y = '0;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XNOR:   y = ~(a ^ b);
      OP_PASS_A: y = a;
      OP_ZERO:   y = '0;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_acc.sv
// Registered bitwise logic unit with pairwise and fold-over-ACC_LEN modes.
module logic_gate_acc
  import logic_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [2:0]       op_sel,
  input  logic             mode,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(ACC_LEN + 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] pair_y;
  logic [WIDTH-1:0] fold_y;

  // Inverting ops fold with their non-inverting base; inversion is applied once at the end
  function automatic logic [2:0] base_op(input logic [2:0] op);
    case (op)
      OP_NAND: base_op = OP_AND;
      OP_NOR:  base_op = OP_OR;
      OP_XNOR: base_op = OP_XOR;
      default: base_op = op;
    endcase
  endfunction

  // Final result shaping: invert for NAND/NOR/XNOR, force zero for ZERO
  function automatic logic [WIDTH-1:0] post(input logic [WIDTH-1:0] x, input logic [2:0] op);
    case (op)
      OP_NAND, OP_NOR, OP_XNOR: post = ~x;
      OP_ZERO:                  post = '0;
      default:                  post = x;
    endcase
  endfunction

  logic_op_core #(.WIDTH(WIDTH)) u_pair (
    .a  (din_a),
    .b  (din_b),
    .op (op_sel),
    .y  (pair_y)
  );

  // New sample goes on operand a so PASS_A yields the most recent sample
  logic_op_core #(.WIDTH(WIDTH)) u_fold (
    .a  (din_a),
    .b  (acc),
    .op (base_op(op_q)),
    .y  (fold_y)
  );

  // Controller: pairwise results, accumulation sequencing and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_AND;
      acc        <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (din_valid) begin
            if (mode == MODE_PAIR) begin
              dout       <= pair_y;
              dout_valid <= 1'b1;
            end else begin
              op_q  <= op_sel;
              acc   <= din_a;
              count <= CNT_W'(1);
              if (ACC_LEN == 1) begin
                dout       <= post(din_a, op_sel);
                dout_valid <= 1'b1;
              end else begin
                state <= ST_ACC;
                busy  <= 1'b1;
              end
            end
          end
        end
        ST_ACC: begin
          // op_sel/mode are ignored here; op_q governs the whole fold
          if (din_valid) begin
            acc   <= fold_y;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(ACC_LEN - 1)) begin
              dout       <= post(fold_y, op_q);
              dout_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_acc.sv
// Directed bench for logic_gate_acc (ACC_LEN=4 and ACC_LEN=1 builds).
module tb_logic_gate_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid, mode;
  logic [7:0] din_a, din_b;
  logic [2:0] op_sel;
  logic [7:0] dout;
  logic       dout_valid, busy;

  logic       din_valid1, mode1;
  logic [7:0] din_a1, din_b1;
  logic [2:0] op_sel1;
  logic [7:0] dout1;
  logic       dout_valid1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_gate_acc #(.WIDTH(8), .ACC_LEN(4)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_a(din_a), .din_b(din_b),
    .op_sel(op_sel), .mode(mode), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  logic_gate_acc #(.WIDTH(8), .ACC_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .din_valid(din_valid1), .din_a(din_a1), .din_b(din_b1),
    .op_sel(op_sel1), .mode(mode1), .dout(dout1), .dout_valid(dout_valid1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    din_valid = v; mode = m; op_sel = op; din_a = a; din_b = b;
  endtask

  task automatic outs(input string tag, input logic [7:0] d, input logic v, input logic b);
    chk({tag, ".dout"},  32'(dout), 32'(d));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
    chk({tag, ".busy"},  32'(busy), 32'(b));
  endtask

  logic [7:0] pair_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h00};
  logic [7:0] and_smp  [4] = '{8'hFF, 8'hF0, 8'h3C, 8'h18};
  logic [7:0] nor_smp  [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 8'hFF, 8'hFF);
    din_valid1 = 1'b1; mode1 = 1'b1; op_sel1 = 3'd5; din_a1 = 8'h5A; din_b1 = 8'h00;

    // Reset held with valid inputs
    for (int i = 0; i < 2; i++) begin
      step();
      outs("reset", 8'h00, 1'b0, 1'b0);
      chk("reset.dout1",  32'(dout1), 32'h00);
      chk("reset.valid1", 32'(dout_valid1), 32'h0);
      chk("reset.busy1",  32'(busy1), 32'h0);
    end
    rst = 1'b0;
    din_valid1 = 1'b0;

    // Pairwise sweep, back-to-back
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 1'b0, 3'(op), 8'hF0, 8'hCC);
      step();
      outs($sformatf("pair%0d", op), pair_exp[op], 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    outs("pair_idle", 8'h00, 1'b0, 1'b0);

    // Accumulate AND with two idle cycles between samples
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b1, 3'd0, and_smp[s], 8'h55);
      step();
      if (s < 3) begin
        outs($sformatf("and_s%0d", s), 8'h00, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
          step();
          outs($sformatf("and_gap%0d_%0d", s, k), 8'h00, 1'b0, 1'b1);
        end
      end else begin
        outs("and_res", 8'h10, 1'b1, 1'b0);
      end
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    outs("and_after", 8'h10, 1'b0, 1'b0);

    // Accumulate NOR; op_sel/mode disturbed from sample 2 on
    for (int s = 0; s < 4; s++) begin
      if (s == 0) drive(1'b1, 1'b1, 3'd4, nor_smp[s], 8'h00);
      else        drive(1'b1, 1'b0, 3'd2, nor_smp[s], 8'hFF);
      step();
      if (s < 3) outs($sformatf("nor_s%0d", s), 8'h10, 1'b0, 1'b1);
      else       outs("nor_res", 8'hF0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    outs("nor_after", 8'hF0, 1'b0, 1'b0);

    // Reset mid-accumulation discards the partial fold
    drive(1'b1, 1'b1, 3'd0, 8'hFF, 8'h00);
    step();
    drive(1'b1, 1'b1, 3'd0, 8'h0F, 8'h00);
    step();
    outs("mid_s1", 8'hF0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    outs("mid_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 1'b1, 3'd0, 8'hAA, 8'h00);
      step();
      if (s < 3) outs($sformatf("aa_s%0d", s), 8'h00, 1'b0, 1'b1);
      else       outs("aa_res", 8'hAA, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);

    // ACC_LEN=1 build: immediate XNOR result
    din_valid1 = 1'b1; mode1 = 1'b1; op_sel1 = 3'd5; din_a1 = 8'h5A; din_b1 = 8'h00;
    step();
    chk("len1.dout",  32'(dout1), 32'hA5);
    chk("len1.valid", 32'(dout_valid1), 32'h1);
    chk("len1.busy",  32'(busy1), 32'h0);
    din_valid1 = 1'b0;
    step();
    chk("len1_after.dout",  32'(dout1), 32'hA5);
    chk("len1_after.valid", 32'(dout_valid1), 32'h0);
    chk("len1_after.busy",  32'(busy1), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
